// File: rtl/uart_tx_frame.sv
// uart_tx_frame: sends a sync header and one frame of pixel bytes from a frame buffer over an 8N1 UART.
// Define UART_TX_CHECKSUM_EN to append an XOR checksum of the pixel bytes after the last pixel.
module uart_tx_frame #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    IMG_WIDTH   = 176,
    parameter int                    IMG_HEIGHT  = 240,
    parameter int                    ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int                    SAMPLING    = 16,
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = 8'hAA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  b_tick,
    input  logic                  tx_start,
    output logic                  fb_re,
    output logic [ADDR_WIDTH-1:0] fb_rAddr,
    input  logic [15:0]           fb_rData,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  frame_tx_done
);

    localparam int                    NUM_PIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
    localparam int                    TICK_W    = $clog2(SAMPLING);
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(SAMPLING - 1);
    localparam int                    BIT_W     = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        FETCH,
        WAIT_RD,
        SEND_PIX,
`ifdef UART_TX_CHECKSUM_EN
        SEND_CSUM,
`endif
        DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_t;

    frame_state_t          state;
    ser_state_t            ser_state;
    logic                  ser_load;
    logic [DATA_WIDTH-1:0] ser_byte;
    logic [DATA_WIDTH-1:0] shreg;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic                  ser_accept;
    logic                  tick_last;
    logic                  byte_done;
    logic                  unused_fb_hi;
`ifdef UART_TX_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    // A pending byte is taken only on a b_tick so that the start bit lasts exactly SAMPLING ticks.
    assign ser_accept   = (ser_state == S_IDLE) && ser_load && b_tick;
    assign tick_last    = b_tick && (tick_cnt == TICK_LAST);
    assign byte_done    = (ser_state == S_STOP) && tick_last;
    assign unused_fb_hi = ^fb_rData[15:DATA_WIDTH];

    // Frame sequencer: header, pixels fetched one at a time, optional checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            fb_re         <= 1'b0;
            fb_rAddr      <= '0;
            tx_busy       <= 1'b0;
            frame_tx_done <= 1'b0;
            ser_load      <= 1'b0;
            ser_byte      <= '0;
`ifdef UART_TX_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle, so a state can only raise them for one cycle.
            fb_re         <= 1'b0;
            frame_tx_done <= 1'b0;
            if (ser_accept) begin
                ser_load <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tx_start) begin
                        state    <= SEND_HDR;
                        tx_busy  <= 1'b1;
                        ser_load <= 1'b1;
                        ser_byte <= HEADER_BYTE;
                        fb_rAddr <= '0;
`ifdef UART_TX_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                SEND_HDR: begin
                    if (byte_done) begin
                        state <= FETCH;
                        fb_re <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    ser_byte <= fb_rData[DATA_WIDTH-1:0];
                    ser_load <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
                    checksum <= checksum ^ fb_rData[DATA_WIDTH-1:0];
`endif
                    state    <= SEND_PIX;
                end
                SEND_PIX: begin
                    if (byte_done) begin
                        if (fb_rAddr == LAST_ADDR) begin
                            fb_rAddr <= '0;
`ifdef UART_TX_CHECKSUM_EN
                            state    <= SEND_CSUM;
                            ser_load <= 1'b1;
                            ser_byte <= checksum;
`else
                            state         <= DONE;
                            frame_tx_done <= 1'b1;
                            tx_busy       <= 1'b0;
`endif
                        end else begin
                            fb_rAddr <= fb_rAddr + ADDR_WIDTH'(1);
                            state    <= FETCH;
                            fb_re    <= 1'b1;
                        end
                    end
                end
`ifdef UART_TX_CHECKSUM_EN
                SEND_CSUM: begin
                    if (byte_done) begin
                        state         <= DONE;
                        frame_tx_done <= 1'b1;
                        tx_busy       <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte serializer: start bit, LSB-first data, stop bit, each held for SAMPLING b_ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_state <= S_IDLE;
            tx        <= 1'b1;
            shreg     <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            case (ser_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (ser_accept) begin
                        shreg     <= ser_byte;
                        tick_cnt  <= '0;
                        ser_state <= S_START;
                        tx        <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick_last) begin
                        tick_cnt  <= '0;
                        bit_idx   <= '0;
                        ser_state <= S_DATA;
                        tx        <= shreg[0];
                    end else if (b_tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            ser_state <= S_STOP;
                            tx        <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else if (b_tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                S_STOP: begin
                    if (tick_last) begin
                        tick_cnt  <= '0;
                        ser_state <= S_IDLE;
                    end else if (b_tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    ser_state <= S_IDLE;
                    tx        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameters, each name / default / meaning:
- DATA_WIDTH / 8 / UART byte width.
- IMG_WIDTH / 176 / pixels per line.
- IMG_HEIGHT / 240 / lines per frame.
- ADDR_WIDTH / $clog2(IMG_WIDTH*IMG_HEIGHT) / frame buffer address width.
- SAMPLING / 16 / b_tick pulses per UART bit.
- HEADER_BYTE / 8'hAA / frame sync byte.
REQ-002 SHALL have ports, each name / direction / width / meaning, clock and reset first:
- clk / in / 1 / single clock; every register is clocked on the rising edge.
- reset / in / 1 / asynchronous, active-high reset.
- b_tick / in / 1 / one-cycle oversampling tick at SAMPLING x baud.
- tx_start / in / 1 / one-cycle request to send one frame.
- fb_re / out / 1 / frame buffer read enable.
- fb_rAddr / out / ADDR_WIDTH / frame buffer read address.
- fb_rData / in / 16 / frame buffer read data, valid the cycle after fb_re.
- tx / out / 1 / UART serial line, idle high.
- tx_busy / out / 1 / high from tx_start acceptance until frame_tx_done.
- frame_tx_done / out / 1 / one-cycle pulse after the last stop bit.

Function
REQ-003 SHALL transmit each frame as HEADER_BYTE, then N=IMG_WIDTH*IMG_HEIGHT pixel bytes (fb_rData[7:0] of address 0..N-1 in order), then the optional checksum byte (REQ-015).
REQ-004 SHALL frame each byte as 8N1: one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1).
REQ-005 SHALL hold every bit on tx for exactly SAMPLING b_tick pulses; the bit period counter SHALL advance only on b_tick.
REQ-006 SHALL drive tx low in the cycle after a byte is loaded into the serializer; the bit counter SHALL start counting from that cycle.
REQ-007 SHALL use frame FSM states IDLE -> SEND_HDR -> FETCH -> WAIT_RD -> SEND_PIX -> (FETCH while bytes remain, else SEND_CSUM or DONE) -> DONE -> IDLE.
REQ-008 SHALL use serializer states S_IDLE -> S_START -> S_DATA -> S_STOP -> S_IDLE and SHALL report byte completion at the end of the stop bit.
REQ-009 SHALL accept tx_start only in IDLE; tx_busy SHALL rise on the next cycle; tx_start while busy SHALL be ignored and SHALL NOT queue.
REQ-010 SHALL assert fb_re for exactly one cycle in FETCH with fb_rAddr = pixel index; SHALL capture fb_rData in WAIT_RD (read latency 1); the next fetch SHALL NOT start until the current byte completes.
REQ-011 SHALL increment fb_rAddr after each pixel byte completes; after pixel N-1 it SHALL wrap to 0 and SHALL NOT exceed N-1.
REQ-012 SHALL pulse frame_tx_done for one cycle in DONE and SHALL deassert tx_busy in the same cycle; a tx_start in that cycle SHALL be ignored.
REQ-013 SHALL keep tx high and fb_re low whenever the block is idle.

Reset
REQ-014 SHALL, on reset assertion at any time including mid-byte or mid-frame:
- immediately force tx=1, tx_busy=0, frame_tx_done=0, fb_re=0, fb_rAddr=0, checksum=0;
- place the frame FSM in IDLE and the serializer in S_IDLE;
- resume with no partial byte after release.

Configuration
REQ-015 SHALL compile the checksum feature under macro UART_TX_CHECKSUM_EN:
- Defined: XOR of all N pixel bytes (header excluded) is sent after the last pixel in SEND_CSUM; frame length is N+2 bytes; the checksum register clears at frame start.
- Undefined: SEND_CSUM and the checksum register are absent; frame length is N+1 bytes.

Verification
REQ-016 SHALL cover the following directed scenarios, with IMG_WIDTH=4, IMG_HEIGHT=2, SAMPLING=16 and b_tick every cycle unless stated:
- Frame content: fb holds byte = address+1; one tx_start -> decoded bytes AA,01..08 (plus checksum 08 with macro defined), each bit 16 cycles, frame_tx_done pulses once, fb_rAddr back to 0.
- Read pattern: one frame -> fb_re pulses exactly 8 times at addresses 0..7, each one cycle, each read only after the previous byte completes.
- Busy ignore: tx_start repeated mid-frame -> exactly one frame transmitted, tx_busy stays high continuously.
- Reset mid-frame: reset asserted during bit 3 of pixel 2 -> tx=1 asynchronously; a new tx_start then restarts from the header at address 0.
- Slow tick: b_tick every 4 cycles -> each bit lasts exactly 64 cycles, data unchanged.
- Back-to-back: tx_start on the cycle after frame_tx_done -> second identical frame, no extra idle bits beyond one cycle.
